// File: rtl/udbn_if.sv
// Bus bundle for the udbn BCD counter: control/load inputs and count/status outputs.
// Clock and reset stay outside the bundle as plain ports.
interface udbn_if #(
  parameter int unsigned DIGITS = 4
) ();

  logic                  udbn_en;
  logic                  udbn_load;
  logic [4*DIGITS-1:0]   udbn_load_input;
  logic                  udbn_direction;
  logic [4*DIGITS-1:0]   udbn_q;
  logic                  udbn_tc;
  logic                  udbn_wrap;
  logic                  udbn_err;

  modport master (
    output udbn_en,
    output udbn_load,
    output udbn_load_input,
    output udbn_direction,
    input  udbn_q,
    input  udbn_tc,
    input  udbn_wrap,
    input  udbn_err
  );

  modport slave (
    input  udbn_en,
    input  udbn_load,
    input  udbn_load_input,
    input  udbn_direction,
    output udbn_q,
    output udbn_tc,
    output udbn_wrap,
    output udbn_err
  );

endinterface

// File: rtl/udbn.sv
// Fully synchronous N-digit BCD up/down counter with parallel load, wrap/saturate mode,
// combinational terminal-count output, registered wrap pulse and sticky bad-load flag.
module udbn #(
  parameter int unsigned DIGITS   = 4,
  parameter bit          SAT_MODE = 1'b0
) (
  input logic   udbn_clk,
  input logic   udbn_rst,
  udbn_if.slave bus
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] cnt_q, cnt_d, step_cnt;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;
  logic         at_term;
  logic         load_ok;

  // Digit i steps only when every lower digit is at its rollover value; this ripple of
  // enables replaces the old derived-clock carry chain.
  always_comb begin : step_logic
    logic [3:0] dig;
    logic [3:0] ld;
    logic       all9;
    logic       all0;
    step_cnt = cnt_q;
    load_ok  = 1'b1;
    all9     = 1'b1;
    all0     = 1'b1;
    dig      = 4'd0;
    ld       = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig = cnt_q[4*i +: 4];
      ld  = bus.udbn_load_input[4*i +: 4];
      if (!bus.udbn_direction && all9) begin
        step_cnt[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
      end else if (bus.udbn_direction && all0) begin
        step_cnt[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      end
      all9 = all9 & (dig == 4'd9);
      all0 = all0 & (dig == 4'd0);
      if (ld > 4'd9) begin
        load_ok = 1'b0;
      end
    end
    at_term = bus.udbn_direction ? all0 : all9;
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (bus.udbn_load) begin
      if (load_ok) begin
        cnt_d = bus.udbn_load_input;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.udbn_en) begin
      // At terminal the stepped value is already the wrapped value (all 0s or all 9s).
      if (!(at_term && SAT_MODE)) begin
        cnt_d = step_cnt;
      end
      wrap_d = at_term && !SAT_MODE;
    end
  end

  always_ff @(posedge udbn_clk or negedge udbn_rst) begin
    if (!udbn_rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.udbn_q    = cnt_q;
  assign bus.udbn_wrap = wrap_q;
  assign bus.udbn_err  = err_q;
  assign bus.udbn_tc   = bus.udbn_en & ~bus.udbn_load & at_term;

endmodule

// File: tb/tb_udbn.sv
// Bench for udbn: a wrap-mode and a saturate-mode instance driven in lockstep and
// compared against an integer-valued reference model of the counter.
module tb_udbn;

  localparam int unsigned DIGITS = 4;
  localparam int          MAXV   = 9999;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] li;
  logic        dir;

  int checks;
  int errors;

  // Reference model state, index 0 = wrap mode, 1 = saturate mode.
  int m_val  [2];
  bit m_wrap [2];
  bit m_err  [2];

  udbn_if #(.DIGITS(DIGITS)) ifw ();
  udbn_if #(.DIGITS(DIGITS)) ifs ();

  assign ifw.udbn_en         = en;
  assign ifw.udbn_load       = load;
  assign ifw.udbn_load_input = li;
  assign ifw.udbn_direction  = dir;
  assign ifs.udbn_en         = en;
  assign ifs.udbn_load       = load;
  assign ifs.udbn_load_input = li;
  assign ifs.udbn_direction  = dir;

  udbn #(.DIGITS(DIGITS), .SAT_MODE(1'b0)) u_wrap (
    .udbn_clk (clk),
    .udbn_rst (rst_n),
    .bus      (ifw.slave)
  );

  udbn #(.DIGITS(DIGITS), .SAT_MODE(1'b1)) u_sat (
    .udbn_clk (clk),
    .udbn_rst (rst_n),
    .bus      (ifs.slave)
  );

  logic [15:0] q_o    [2];
  logic        tc_o   [2];
  logic        wrap_o [2];
  logic        err_o  [2];

  assign q_o[0]    = ifw.udbn_q;
  assign q_o[1]    = ifs.udbn_q;
  assign tc_o[0]   = ifw.udbn_tc;
  assign tc_o[1]   = ifs.udbn_tc;
  assign wrap_o[0] = ifw.udbn_wrap;
  assign wrap_o[1] = ifs.udbn_wrap;
  assign err_o[0]  = ifw.udbn_err;
  assign err_o[1]  = ifs.udbn_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [15:0] b);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit is_bcd(input logic [15:0] b);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic bit model_tc(input int k);
    bit term;
    term = dir ? (m_val[k] == 0) : (m_val[k] == MAXV);
    return en && !load && term;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k]  = 0;
      m_wrap[k] = 1'b0;
      m_err[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 1'b0;
      if (load) begin
        if (is_bcd(li)) begin
          m_val[k] = bcd2int(li);
          m_err[k] = 1'b0;
        end else begin
          m_err[k] = 1'b1;
        end
      end else if (en) begin
        if (!dir && m_val[k] == MAXV) begin
          if (k == 0) begin
            m_val[k]  = 0;
            m_wrap[k] = 1'b1;
          end
        end else if (dir && m_val[k] == 0) begin
          if (k == 0) begin
            m_val[k]  = MAXV;
            m_wrap[k] = 1'b1;
          end
        end else begin
          m_val[k] = dir ? m_val[k] - 1 : m_val[k] + 1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: got %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_q"}, k, 32'(q_o[k]), 32'(int2bcd(m_val[k])));
      check({tag, "_wrap"}, k, 32'(wrap_o[k]), 32'(m_wrap[k]));
      check({tag, "_err"}, k, 32'(err_o[k]), 32'(m_err[k]));
    end
  endtask

  // Apply inputs, check tc before the edge, clock once, then check registered state.
  task automatic step(input string tag, input logic e, input logic l, input logic [15:0] v,
                      input logic d);
    en   = e;
    load = l;
    li   = v;
    dir  = d;
    #1;
    for (int k = 0; k < 2; k++) check({tag, "_tc"}, k, 32'(tc_o[k]), 32'(model_tc(k)));
    @(posedge clk);
    model_edge();
    #1;
    check_state(tag);
  endtask

  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] v;
    checks = 0;
    errors = 0;
    en     = 1'b0;
    load   = 1'b0;
    li     = '0;
    dir    = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    #3;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-count, then count from zero.
    step("ld42", 1'b0, 1'b1, 16'h0042, 1'b0);
    mid_reset("async_rst");
    for (int i = 0; i < 3; i++) step("up_after_rst", 1'b1, 1'b0, 16'h0000, 1'b0);
    check("rst_then_3", 0, 32'(q_o[0]), 32'h0003);

    // Carry and borrow chains.
    step("ld199", 1'b0, 1'b1, 16'h0199, 1'b0);
    step("carry1", 1'b1, 1'b0, 16'h0000, 1'b0);
    check("carry_0200", 0, 32'(q_o[0]), 32'h0200);
    step("carry2", 1'b1, 1'b0, 16'h0000, 1'b0);
    check("carry_0201", 0, 32'(q_o[0]), 32'h0201);
    step("ld1000", 1'b0, 1'b1, 16'h1000, 1'b1);
    step("borrow", 1'b1, 1'b0, 16'h0000, 1'b1);
    check("borrow_0999", 0, 32'(q_o[0]), 32'h0999);

    // Up wrap / saturate.
    step("ld9998", 1'b0, 1'b1, 16'h9998, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("wrap_up", 1'b1, 1'b0, 16'h0000, 1'b0);
      if (i == 1) check("wrap_pulse", 0, 32'(wrap_o[0]), 32'h1);
    end
    check("after_wrap_up", 0, 32'(q_o[0]), 32'h0001);

    // Down wrap.
    step("ld0001", 1'b0, 1'b1, 16'h0001, 1'b1);
    for (int i = 0; i < 3; i++) step("wrap_dn", 1'b1, 1'b0, 16'h0000, 1'b1);

    // Saturation held at 9999, then reverse.
    step("ld9999", 1'b0, 1'b1, 16'h9999, 1'b0);
    for (int i = 0; i < 5; i++) step("sat_up", 1'b1, 1'b0, 16'h0000, 1'b0);
    check("sat_hold", 1, 32'(q_o[1]), 32'h9999);
    step("sat_rev", 1'b1, 1'b0, 16'h0000, 1'b1);
    check("sat_rev_9998", 1, 32'(q_o[1]), 32'h9998);

    // Bad load keeps q, sets sticky err; valid load clears it.
    step("badld", 1'b0, 1'b1, 16'h0A12, 1'b0);
    check("bad_err", 0, 32'(err_o[0]), 32'h1);
    step("bad_cnt", 1'b1, 1'b0, 16'h0000, 1'b0);
    step("goodld", 1'b0, 1'b1, 16'h0012, 1'b0);
    check("good_q", 0, 32'(q_o[0]), 32'h0012);

    // Load beats enable; then hold with en low.
    step("prio", 1'b1, 1'b1, 16'h0500, 1'b0);
    check("prio_q", 0, 32'(q_o[0]), 32'h0500);
    for (int i = 0; i < 4; i++) step("hold", 1'b0, 1'b0, 16'h0000, 1'b0);

    // Randomised traffic, biased toward terminal values.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0:       v = 16'(int'($urandom));
        1:       v = 16'h9999;
        2:       v = 16'h0000;
        default: v = int2bcd(int'($urandom_range(0, MAXV)));
      endcase
      step("rand", 1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 9) == 0), v,
           1'($urandom_range(0, 7) == 0) ^ dir);
      if ($urandom_range(0, 49) == 0) mid_reset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
